// File: rtl/wb_test_pkg.sv
// Shared encodings for the Wishbone pattern initiator and its companion checkers:
// run modes, FSM state codes, transfer phase and the LFSR definition.
package wb_test_pkg;

    localparam logic [1:0] MODE_WR    = 2'b00;
    localparam logic [1:0] MODE_RD    = 2'b01;
    localparam logic [1:0] MODE_WR_RD = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic PHASE_WR = 1'b0;
    localparam logic PHASE_RD = 1'b1;

    localparam logic [31:0] LFSR_POLY    = 32'h0040_0007;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Galois-style left shift: the polynomial is folded in when bit 31 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit pattern LFSR with load and advance; shared by initiator and responder checkers.
module lfsr32
    import wb_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        advance,
    output logic [31:0] state
);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= DEFAULT_SEED;
        else if (load)
            state <= load_val;
        else if (advance)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/wb_pattern_initiator.sv
// Wishbone classic initiator running LFSR-patterned write / read-check bursts
// over a word window, counting mismatches, bus errors and timeouts.
module wb_pattern_initiator
    import wb_test_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_adr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      seed_i,
    input  logic [1:0]       mode_i,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      err_cnt_o,
    output logic             timeout_o,
    output logic             fail_o
);

    logic [1:0]       state;
    logic             phase;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [31:0]      base_q;
    logic [31:0]      seed_q;
    logic [31:0]      adr_q;
    logic [15:0]      wait_cnt;
    logic [31:0]      pattern;

    logic [31:0] seed_eff;
    logic        in_req;
    logic        xfer_end;
    logic        last_word;
    logic        to_read_phase;
    logic        timed_out;
    logic        bump_err;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic [31:0] lfsr_load_val;

    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^base_adr_i[1:0];

    assign seed_eff      = (seed_i == 32'h0) ? DEFAULT_SEED : seed_i;
    assign in_req        = (state == ST_REQ);
    assign xfer_end      = wbm_ack_i | wbm_err_i;
    assign last_word     = (idx == len_q - LEN_W'(1));
    assign to_read_phase = (mode_q == MODE_WR_RD) && (phase == PHASE_WR);
    assign timed_out     = (wait_cnt == 16'(TIMEOUT - 1));
    // err wins over ack, so a simultaneous ack+err is counted exactly once.
    assign bump_err      = wbm_err_i | (wbm_ack_i & (phase == PHASE_RD) & (wbm_dat_i != pattern));

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;
        lfsr_load_val = seed_q;
        if (state == ST_IDLE && start_i) begin
            lfsr_load     = 1'b1;
            lfsr_load_val = seed_eff;
        end else if (in_req && xfer_end) begin
            lfsr_load = last_word && to_read_phase;
            lfsr_adv  = !last_word;
        end
    end

    lfsr32 u_lfsr (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .advance  (lfsr_adv),
        .state    (pattern)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            phase     <= PHASE_WR;
            mode_q    <= MODE_WR;
            len_q     <= '0;
            idx       <= '0;
            base_q    <= 32'h0;
            seed_q    <= DEFAULT_SEED;
            adr_q     <= 32'h0;
            wait_cnt  <= 16'h0;
            err_cnt_o <= 16'h0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
                    base_q    <= {base_adr_i[31:2], 2'b00};
                    adr_q     <= {base_adr_i[31:2], 2'b00};
                    len_q     <= len_i;
                    seed_q    <= seed_eff;
                    mode_q    <= mode_i;
                    idx       <= '0;
                    wait_cnt  <= 16'h0;
                    err_cnt_o <= 16'h0;
                    timeout_o <= 1'b0;
                    phase     <= (mode_i == MODE_RD) ? PHASE_RD : PHASE_WR;
                    state     <= (len_i == '0 || mode_i == MODE_RSVD) ? ST_DONE : ST_REQ;
                end
                ST_REQ: begin
                    if (xfer_end) begin
                        if (bump_err && err_cnt_o != 16'hFFFF)
                            err_cnt_o <= err_cnt_o + 16'd1;
                        if (!last_word) begin
                            idx   <= idx + LEN_W'(1);
                            adr_q <= adr_q + 32'd4;
                            state <= ST_GAP;
                        end else if (to_read_phase) begin
                            phase <= PHASE_RD;
                            idx   <= '0;
                            adr_q <= base_q;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (timed_out) begin
                        timeout_o <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    wait_cnt <= 16'h0;
                    state    <= ST_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wbm_cyc_o = in_req;
    assign wbm_stb_o = in_req;
    assign wbm_we_o  = in_req && (phase == PHASE_WR);
    assign wbm_sel_o = in_req ? 4'hF : 4'h0;
    assign wbm_adr_o = in_req ? adr_q : 32'h0;
    assign wbm_dat_o = (in_req && phase == PHASE_WR) ? pattern : 32'h0;
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);
    assign fail_o    = (err_cnt_o != 16'h0) || timeout_o;

endmodule

// File: tb/tb_wb_pattern_initiator.sv
// Directed bench for wb_pattern_initiator: a small Wishbone RAM slave with
// configurable wait states, silence, error and corruption injection.
module tb_wb_pattern_initiator;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] base_adr_i;
    logic [7:0]  len_i;
    logic [31:0] seed_i;
    logic [1:0]  mode_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic        busy_o, done_o, timeout_o, fail_o;
    logic [15:0] err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration, driven from the initial block
    bit rand_wait;
    int silent_from;
    int err_idx;
    int both_idx;
    int corrupt_idx;

    // slave / monitor state
    int          xfer_idx = 0;
    int          wcnt = 0;
    int          wtarget = 0;
    int          done_cnt = 0;
    int          cyc_cycles = 0;
    int          gap_viol = 0;
    int          sel_viol = 0;
    bit          prev_end = 1'b0;
    logic [31:0] ram [64];
    bit          log_we  [64];
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic        resp;

    wb_pattern_initiator #(.TIMEOUT(15), .LEN_W(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start_i),
        .base_adr_i (base_adr_i),
        .len_i      (len_i),
        .seed_i     (seed_i),
        .mode_i     (mode_i),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_cnt_o  (err_cnt_o),
        .timeout_o  (timeout_o),
        .fail_o     (fail_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        resp      = wbm_cyc_o && wbm_stb_o && (xfer_idx < silent_from) && (wcnt >= wtarget);
        wbm_err_i = resp && (xfer_idx == err_idx || xfer_idx == both_idx);
        wbm_ack_i = resp && (xfer_idx != err_idx);
        wbm_dat_i = ram[wbm_adr_o[7:2]] ^ ((xfer_idx == corrupt_idx) ? 32'h1 : 32'h0);
    end

    always @(posedge clk) begin
        prev_end <= wbm_cyc_o && (wbm_ack_i || wbm_err_i);
        if (prev_end && wbm_cyc_o) gap_viol <= gap_viol + 1;
        if (wbm_cyc_o && wbm_sel_o != 4'hF) sel_viol <= sel_viol + 1;
        if (wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (start_i && !busy_o && !rst) begin
            xfer_idx   <= 0;
            wcnt       <= 0;
            done_cnt   <= 0;
            cyc_cycles <= 0;
            gap_viol   <= 0;
            sel_viol   <= 0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (wbm_ack_i || wbm_err_i) begin
                if (xfer_idx < 64) begin
                    log_we[xfer_idx]  <= wbm_we_o;
                    log_adr[xfer_idx] <= wbm_adr_o;
                    log_dat[xfer_idx] <= wbm_we_o ? wbm_dat_o : wbm_dat_i;
                end
                if (wbm_we_o && wbm_ack_i && !wbm_err_i) ram[wbm_adr_o[7:2]] <= wbm_dat_o;
                xfer_idx <= xfer_idx + 1;
                wcnt     <= 0;
                wtarget  <= rand_wait ? int'($urandom_range(3, 0)) : 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
        logic [31:0] s = seed;
        for (int i = 0; i < k; i++)
            s = (s << 1) ^ ({32{s[31]}} & 32'h0040_0007);
        return s;
    endfunction

    task automatic slave_cfg(input bit rw, input int sil, input int ei, input int bi, input int ci);
        rand_wait = rw; silent_from = sil; err_idx = ei; both_idx = bi; corrupt_idx = ci;
    endtask

    task automatic run_start(input logic [31:0] base, input logic [7:0] len,
                             input logic [31:0] seed, input logic [1:0] mode);
        @(negedge clk);
        base_adr_i = base; len_i = len; seed_i = seed; mode_i = mode; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (busy_o && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy still %b after %0d cycles, want 0", name, busy_o, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'h0) begin
            n_bad++; $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h, want all 0", wbm_cyc_o, wbm_stb_o, wbm_adr_o);
        end
        n_cmp++;
        if ({busy_o, done_o, timeout_o, fail_o, err_cnt_o} !== 20'h0) begin
            n_bad++; $display("FAIL reset_status: got busy=%b done=%b to=%b fail=%b err=%0d, want 0", busy_o, done_o, timeout_o, fail_o, err_cnt_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_only();
        logic [31:0] exp_dat [3] = '{32'h1, 32'h2, 32'h4};
        slave_cfg(0, 1000, -1, -1, -1);
        run_start(32'h3000_0000, 8'd3, 32'h1, 2'b00);
        wait_idle(100, "wr");
        n_cmp++; if (xfer_idx !== 3) begin n_bad++; $display("FAIL wr_count: got %0d want 3", xfer_idx); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (log_we[k] !== 1'b1 || log_adr[k] !== 32'h3000_0000 + 4 * k || log_dat[k] !== exp_dat[k]) begin
                n_bad++; $display("FAIL wr_word%0d: got we=%b adr=%h dat=%h, want we=1 adr=%h dat=%h",
                                  k, log_we[k], log_adr[k], log_dat[k], 32'h3000_0000 + 4 * k, exp_dat[k]);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL wr_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (err_cnt_o !== 16'd0 || fail_o !== 1'b0) begin n_bad++; $display("FAIL wr_status: got err=%0d fail=%b want 0/0", err_cnt_o, fail_o); end
        n_cmp++; if (gap_viol !== 0 || sel_viol !== 0) begin n_bad++; $display("FAIL wr_gap_sel: got gap_viol=%0d sel_viol=%0d want 0/0", gap_viol, sel_viol); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_adr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] exp_dat [3] = '{32'h8000_0000, 32'h0040_0007, 32'h0080_000E};
        slave_cfg(0, 1000, -1, -1, -1);
        run_start(32'hFFFF_FFFB, 8'd3, 32'h8000_0000, 2'b00);
        wait_idle(100, "wrap");
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (log_adr[k] !== exp_adr[k] || log_dat[k] !== exp_dat[k]) begin
                n_bad++; $display("FAIL wrap_word%0d: got adr=%h dat=%h, want adr=%h dat=%h", k, log_adr[k], log_dat[k], exp_adr[k], exp_dat[k]);
            end
        end
    endtask

    task automatic test_write_read(input int corrupt, input int exp_err);
        logic [31:0] base = 32'h0000_0100;
        slave_cfg(1, 1000, -1, -1, corrupt);
        run_start(base, 8'd16, 32'hDEAD_BEEF, 2'b10);
        wait_idle(400, "wrrd");
        n_cmp++; if (xfer_idx !== 32) begin n_bad++; $display("FAIL wrrd_count: got %0d want 32", xfer_idx); end
        for (int k = 0; k < 32; k++) begin
            logic [31:0] ea = base + 4 * (k % 16);
            logic [31:0] ed = model_word(32'hDEAD_BEEF, k % 16) ^ ((k == corrupt) ? 32'h1 : 32'h0);
            n_cmp++;
            if (log_we[k] !== (k < 16) || log_adr[k] !== ea || log_dat[k] !== ed) begin
                n_bad++; $display("FAIL wrrd_xfer%0d: got we=%b adr=%h dat=%h, want we=%b adr=%h dat=%h",
                                  k, log_we[k], log_adr[k], log_dat[k], k < 16, ea, ed);
            end
        end
        n_cmp++; if (err_cnt_o !== 16'(exp_err)) begin n_bad++; $display("FAIL wrrd_err: got %0d want %0d", err_cnt_o, exp_err); end
        n_cmp++; if (fail_o !== (exp_err != 0)) begin n_bad++; $display("FAIL wrrd_fail: got %b want %b", fail_o, exp_err != 0); end
        n_cmp++; if (done_cnt !== 1 || gap_viol !== 0) begin n_bad++; $display("FAIL wrrd_done_gap: got done=%0d gap_viol=%0d want 1/0", done_cnt, gap_viol); end
    endtask

    task automatic test_timeout();
        slave_cfg(0, 0, -1, -1, -1);
        run_start(32'h0000_0000, 8'd4, 32'h1, 2'b00);
        wait_idle(100, "to");
        n_cmp++; if (cyc_cycles !== 15) begin n_bad++; $display("FAIL to_cyc_len: got %0d cycles want 15", cyc_cycles); end
        n_cmp++; if (timeout_o !== 1'b1 || fail_o !== 1'b1) begin n_bad++; $display("FAIL to_flags: got to=%b fail=%b want 1/1", timeout_o, fail_o); end
        n_cmp++; if (done_cnt !== 1 || xfer_idx !== 0) begin n_bad++; $display("FAIL to_done: got done=%0d xfers=%0d want 1/0", done_cnt, xfer_idx); end
        repeat (10) @(negedge clk);
        n_cmp++; if (cyc_cycles !== 15 || timeout_o !== 1'b1) begin n_bad++; $display("FAIL to_after: got cyc_cycles=%0d to=%b want 15/1", cyc_cycles, timeout_o); end
    endtask

    task automatic test_bus_error();
        slave_cfg(0, 1000, 1, -1, -1);
        run_start(32'h0000_0200, 8'd4, 32'h1, 2'b00);
        wait_idle(100, "berr");
        n_cmp++; if (xfer_idx !== 4 || err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL berr_cnt: got xfers=%0d err=%0d want 4/1", xfer_idx, err_cnt_o); end
        n_cmp++; if (log_adr[3] !== 32'h0000_020C || log_dat[3] !== 32'h8) begin n_bad++; $display("FAIL berr_last: got adr=%h dat=%h want 0000020c/00000008", log_adr[3], log_dat[3]); end
        n_cmp++; if (timeout_o !== 1'b0 || fail_o !== 1'b1) begin n_bad++; $display("FAIL berr_flags: got to=%b fail=%b want 0/1", timeout_o, fail_o); end
        slave_cfg(0, 1000, -1, 2, -1);
        run_start(32'h0000_0200, 8'd4, 32'h1, 2'b00);
        wait_idle(100, "both");
        n_cmp++; if (xfer_idx !== 4 || err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL both_cnt: got xfers=%0d err=%0d want 4/1", xfer_idx, err_cnt_o); end
    endtask

    task automatic test_noop(input logic [7:0] len, input logic [1:0] mode, input string name);
        slave_cfg(0, 1000, -1, -1, -1);
        run_start(32'h0000_0000, len, 32'h1, mode);
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_t1: got done=%b busy=%b cyc=%b want 1/1/0", name, done_o, busy_o, wbm_cyc_o); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0 || cyc_cycles !== 0) begin
            n_bad++; $display("FAIL %s_t2: got done=%b busy=%b cyc_cycles=%0d want 0/0/0", name, done_o, busy_o, cyc_cycles); end
    endtask

    task automatic test_start_while_busy();
        slave_cfg(0, 1000, -1, -1, -1);
        run_start(32'h0000_0300, 8'd3, 32'h1, 2'b00);
        base_adr_i = 32'h0000_0800; len_i = 8'd9; mode_i = 2'b10; start_i = 1'b1;
        repeat (2) @(negedge clk);
        start_i = 1'b0;
        wait_idle(100, "busy_start");
        n_cmp++; if (xfer_idx !== 3 || log_adr[2] !== 32'h0000_0308 || done_cnt !== 1) begin
            n_bad++; $display("FAIL busy_start: got xfers=%0d adr2=%h done=%0d want 3/00000308/1", xfer_idx, log_adr[2], done_cnt); end
    endtask

    task automatic test_reset_mid();
        slave_cfg(0, 1, 0, -1, -1);
        run_start(32'h0000_0400, 8'd4, 32'h1, 2'b00);
        repeat (3) @(negedge clk);
        n_cmp++; if (wbm_cyc_o !== 1'b1 || err_cnt_o !== 16'd1) begin
            n_bad++; $display("FAIL rstmid_pre: got cyc=%b err=%0d want 1/1", wbm_cyc_o, err_cnt_o); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (wbm_cyc_o !== 1'b0 || busy_o !== 1'b0 || err_cnt_o !== 16'd0) begin
            n_bad++; $display("FAIL rstmid_post: got cyc=%b busy=%b err=%0d want 0/0/0", wbm_cyc_o, busy_o, err_cnt_o); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (done_cnt !== 0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_nodone: got done=%0d busy=%b want 0/0", done_cnt, busy_o); end
    endtask

    task automatic test_seed_zero();
        slave_cfg(0, 1000, -1, -1, -1);
        run_start(32'h0000_0500, 8'd2, 32'h0, 2'b00);
        wait_idle(100, "seed0");
        n_cmp++; if (log_dat[0] !== 32'h1 || log_dat[1] !== 32'h2) begin
            n_bad++; $display("FAIL seed0: got %h/%h want 00000001/00000002", log_dat[0], log_dat[1]); end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_adr_i = 32'h0; len_i = 8'd0; seed_i = 32'h0; mode_i = 2'b00;
        slave_cfg(0, 1000, -1, -1, -1);
        test_reset();
        test_write_only();
        test_wrap();
        test_write_read(-1, 0);
        test_write_read(21, 1);
        test_timeout();
        test_bus_error();
        test_noop(8'd0, 2'b00, "len0");
        test_noop(8'd5, 2'b11, "mode11");
        test_start_while_busy();
        test_reset_mid();
        test_seed_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
